// File: rtl/ofs_fim_pcie_ss_shims_pkg.sv
// Shared types for the PCIe subsystem shims.
//   HDR_WIDTH    : width of one TLP header.
//   t_tuser_seg  : per-segment sideband carried in tuser (vendor bits,
//                  last_segment flag, header-valid flag, header).
package ofs_fim_pcie_ss_shims_pkg;

  localparam int HDR_WIDTH    = 256;
  localparam int VENDOR_WIDTH = 10;

  typedef struct packed {
    logic [VENDOR_WIDTH-1:0] vendor;
    logic                    last_segment;
    logic                    hvalid;
    logic [HDR_WIDTH-1:0]    hdr;
  } t_tuser_seg;

endpackage

// File: rtl/ofs_fim_pcie_ss_hdr_ser_pick.sv
// Lowest-set-bit picker, purely combinational.
// Ports:
//   pending_i : request vector
//   onehot_o  : one-hot of the lowest set bit (all zero when none set)
//   idx_o     : binary index of the lowest set bit (0 when none set)
module ofs_fim_pcie_ss_hdr_ser_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     pending_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan high to low so the last hit, i.e. the lowest index, wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ofs_fim_pcie_ss_hdr_serializer.sv
// Header serializer: holds one AXI-S beat, emits every valid per-segment
// header on the hdr_* stream in ascending segment order, then releases the
// beat on tx_* with the tuser hvalid/hdr fields cleared.
// Ports:
//   clk, rst                    : clock, async active-high reset
//   rx_t*                       : inbound beats (tuser = NUM_SEG x t_tuser_seg)
//   tx_t*                       : outbound data beats, same widths as rx
//   hdr_tvalid/tready/tdata     : one header per handshake
//   hdr_seg                     : segment index the header came from
//   hdr_cnt (optional)          : saturating header handshake counter,
//                                 present when OFS_FIM_PCIE_SS_HDR_SERIALIZER_STATS_EN
//                                 is defined
module ofs_fim_pcie_ss_hdr_serializer
  import ofs_fim_pcie_ss_shims_pkg::*;
#(
  parameter int NUM_SEG        = 2,
  parameter int SEG_DATA_WIDTH = 256
) (
  input  logic                                         clk,
  input  logic                                         rst,

  input  logic                                         rx_tvalid,
  output logic                                         rx_tready,
  input  logic [NUM_SEG*SEG_DATA_WIDTH-1:0]            rx_tdata,
  input  logic [NUM_SEG*SEG_DATA_WIDTH/8-1:0]          rx_tkeep,
  input  logic                                         rx_tlast,
  input  t_tuser_seg [NUM_SEG-1:0]                     rx_tuser,

  output logic                                         tx_tvalid,
  input  logic                                         tx_tready,
  output logic [NUM_SEG*SEG_DATA_WIDTH-1:0]            tx_tdata,
  output logic [NUM_SEG*SEG_DATA_WIDTH/8-1:0]          tx_tkeep,
  output logic                                         tx_tlast,
  output t_tuser_seg [NUM_SEG-1:0]                     tx_tuser,

  output logic                                         hdr_tvalid,
  input  logic                                         hdr_tready,
  output logic [HDR_WIDTH-1:0]                         hdr_tdata,
  output logic [((NUM_SEG > 1) ? $clog2(NUM_SEG) : 1)-1:0] hdr_seg
`ifdef OFS_FIM_PCIE_SS_HDR_SERIALIZER_STATS_EN
  ,
  output logic [31:0]                                  hdr_cnt
`endif
);

  localparam int SEG_IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int DATA_W    = NUM_SEG * SEG_DATA_WIDTH;
  localparam int KEEP_W    = DATA_W / 8;

  logic                            beat_valid_q, beat_valid_d;
  logic                            rdy_en_q;
  logic [NUM_SEG-1:0]              pending_q, pending_d;
  logic [DATA_W-1:0]               tdata_q;
  logic [KEEP_W-1:0]               tkeep_q;
  logic                            tlast_q;
  t_tuser_seg [NUM_SEG-1:0]        tuser_q;

  logic [NUM_SEG-1:0]              rx_hvalid;
  logic [NUM_SEG-1:0]              pick_onehot;
  logic [SEG_IDX_W-1:0]            pick_idx;
  logic                            rx_fire, hdr_fire, tx_fire;

  ofs_fim_pcie_ss_hdr_ser_pick #(
    .N     (NUM_SEG),
    .IDX_W (SEG_IDX_W)
  ) u_pick (
    .pending_i (pending_q),
    .onehot_o  (pick_onehot),
    .idx_o     (pick_idx)
  );

  always_comb begin
    rx_hvalid = '0;
    for (int s = 0; s < NUM_SEG; s++) rx_hvalid[s] = rx_tuser[s].hvalid;
  end

  // rdy_en_q keeps rx_tready low during reset and for the cycle up to the
  // first clock edge after release.
  assign hdr_tvalid = beat_valid_q && (|pending_q);
  assign tx_tvalid  = beat_valid_q && (pending_q == '0);
  assign rx_tready  = rdy_en_q && (!beat_valid_q || (tx_tvalid && tx_tready));

  assign rx_fire  = rx_tvalid && rx_tready;
  assign hdr_fire = hdr_tvalid && hdr_tready;
  assign tx_fire  = tx_tvalid && tx_tready;

  assign hdr_tdata = tuser_q[pick_idx].hdr;
  assign hdr_seg   = pick_idx;

  assign tx_tdata = tdata_q;
  assign tx_tkeep = tkeep_q;
  assign tx_tlast = tlast_q;

  always_comb begin
    tx_tuser = tuser_q;
    for (int s = 0; s < NUM_SEG; s++) begin
      tx_tuser[s].hvalid = 1'b0;
      tx_tuser[s].hdr    = '0;
    end
  end

  // A capture only happens with the slot empty or retiring (pending == 0),
  // so it never collides with a header handshake.
  always_comb begin
    beat_valid_d = beat_valid_q;
    pending_d    = pending_q;
    if (hdr_fire) pending_d = pending_q & ~pick_onehot;
    if (tx_fire)  beat_valid_d = 1'b0;
    if (rx_fire) begin
      beat_valid_d = 1'b1;
      pending_d    = rx_hvalid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_valid_q <= 1'b0;
      pending_q    <= '0;
      rdy_en_q     <= 1'b0;
    end else begin
      beat_valid_q <= beat_valid_d;
      pending_q    <= pending_d;
      rdy_en_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_fire) begin
      tdata_q <= rx_tdata;
      tkeep_q <= rx_tkeep;
      tlast_q <= rx_tlast;
      tuser_q <= rx_tuser;
    end
  end

`ifdef OFS_FIM_PCIE_SS_HDR_SERIALIZER_STATS_EN
  logic [31:0] hdr_cnt_q, hdr_cnt_d;

  always_comb begin
    hdr_cnt_d = hdr_cnt_q;
    if (hdr_fire && (hdr_cnt_q != 32'hFFFF_FFFF)) hdr_cnt_d = hdr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hdr_cnt_q <= '0;
    else     hdr_cnt_q <= hdr_cnt_d;
  end

  assign hdr_cnt = hdr_cnt_q;
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_hdr_serializer.sv
module tb_ofs_fim_pcie_ss_hdr_serializer;
  import ofs_fim_pcie_ss_shims_pkg::*;

  localparam int NS = 2;
  localparam int DW = NS * 256;
  localparam int KW = DW / 8;

  typedef t_tuser_seg [NS-1:0] tu_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx_tvalid, rx_tready, rx_tlast;
  logic [DW-1:0]   rx_tdata;
  logic [KW-1:0]   rx_tkeep;
  tu_t             rx_tuser;
  logic            tx_tvalid, tx_tready, tx_tlast;
  logic [DW-1:0]   tx_tdata;
  logic [KW-1:0]   tx_tkeep;
  tu_t             tx_tuser;
  logic            hdr_tvalid, hdr_tready;
  logic [255:0]    hdr_tdata;
  logic [0:0]      hdr_seg;
`ifdef OFS_FIM_PCIE_SS_HDR_SERIALIZER_STATS_EN
  logic [31:0]     hdr_cnt;
`endif

  ofs_fim_pcie_ss_hdr_serializer #(.NUM_SEG(NS), .SEG_DATA_WIDTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_tvalid  (rx_tvalid),
    .rx_tready  (rx_tready),
    .rx_tdata   (rx_tdata),
    .rx_tkeep   (rx_tkeep),
    .rx_tlast   (rx_tlast),
    .rx_tuser   (rx_tuser),
    .tx_tvalid  (tx_tvalid),
    .tx_tready  (tx_tready),
    .tx_tdata   (tx_tdata),
    .tx_tkeep   (tx_tkeep),
    .tx_tlast   (tx_tlast),
    .tx_tuser   (tx_tuser),
    .hdr_tvalid (hdr_tvalid),
    .hdr_tready (hdr_tready),
    .hdr_tdata  (hdr_tdata),
    .hdr_seg    (hdr_seg)
`ifdef OFS_FIM_PCIE_SS_HDR_SERIALIZER_STATS_EN
    ,
    .hdr_cnt    (hdr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rv;
    bit [1:0] hv;
    bit [7:0] h0, h1, dt;
    bit       txr, hr;
    bit       e_rxr, e_hv, e_seg;
    bit [7:0] e_hdr;
    bit       e_tv;
    bit [7:0] e_dt;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   vid   = 0;

  function automatic logic [DW-1:0] mk_data(bit [7:0] t);
    logic [DW-1:0] d;
    d = '0;
    d[7:0]     = t;
    d[263:256] = t ^ 8'h5A;
    d[511:504] = ~t;
    return d;
  endfunction

  function automatic logic [KW-1:0] mk_keep(bit [7:0] t);
    logic [KW-1:0] k;
    k = '1;
    k[7:0] = t;
    return k;
  endfunction

  function automatic logic [255:0] mk_hdr(bit [7:0] h);
    logic [255:0] x;
    x = '0;
    x[7:0]     = h;
    x[255:248] = ~h;
    return x;
  endfunction

  function automatic tu_t mk_user(bit [7:0] t, bit [1:0] hv, bit [7:0] h0, bit [7:0] h1);
    tu_t u;
    u[0].vendor       = {2'b00, t};
    u[0].last_segment = 1'b0;
    u[0].hvalid       = hv[0];
    u[0].hdr          = mk_hdr(h0);
    u[1].vendor       = {2'b00, t} + 10'd1;
    u[1].last_segment = t[1];
    u[1].hvalid       = hv[1];
    u[1].hdr          = mk_hdr(h1);
    return u;
  endfunction

  function automatic tu_t mk_tx_user(bit [7:0] t);
    tu_t u;
    u = mk_user(t, 2'b00, 8'h00, 8'h00);
    u[0].hdr = '0;
    u[1].hdr = '0;
    return u;
  endfunction

  function automatic void add(bit rv, bit [1:0] hv, bit [7:0] h0, bit [7:0] h1, bit [7:0] dt,
                              bit txr, bit hr, bit e_rxr, bit e_hv, bit e_seg, bit [7:0] e_hdr,
                              bit e_tv, bit [7:0] e_dt);
    vec_t v;
    v.rv = rv; v.hv = hv; v.h0 = h0; v.h1 = h1; v.dt = dt; v.txr = txr; v.hr = hr;
    v.e_rxr = e_rxr; v.e_hv = e_hv; v.e_seg = e_seg; v.e_hdr = e_hdr;
    v.e_tv = e_tv; v.e_dt = e_dt;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, logic [599:0] got, logic [599:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic apply_vec(vec_t v);
    string tg;
    @(negedge clk);
    rx_tvalid  = v.rv;
    rx_tdata   = mk_data(v.dt);
    rx_tkeep   = mk_keep(v.dt);
    rx_tlast   = v.dt[0];
    rx_tuser   = mk_user(v.dt, v.hv, v.h0, v.h1);
    tx_tready  = v.txr;
    hdr_tready = v.hr;
    #1;
    tg = $sformatf("v%0d", vid);
    vid++;
    check({tg, ".rx_tready"},  600'(rx_tready),  600'(v.e_rxr));
    check({tg, ".hdr_tvalid"}, 600'(hdr_tvalid), 600'(v.e_hv));
    check({tg, ".tx_tvalid"},  600'(tx_tvalid),  600'(v.e_tv));
    if (v.e_hv) begin
      check({tg, ".hdr_seg"},   600'(hdr_seg),   600'(v.e_seg));
      check({tg, ".hdr_tdata"}, 600'(hdr_tdata), 600'(mk_hdr(v.e_hdr)));
    end
    if (v.e_tv) begin
      check({tg, ".tx_tdata"}, 600'(tx_tdata), 600'(mk_data(v.e_dt)));
      check({tg, ".tx_tkeep"}, 600'(tx_tkeep), 600'(mk_keep(v.e_dt)));
      check({tg, ".tx_tlast"}, 600'(tx_tlast), 600'(v.e_dt[0]));
      check({tg, ".tx_tuser"}, 600'(tx_tuser), 600'(mk_tx_user(v.e_dt)));
    end
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) apply_vec(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    rst = 1'b1;
    rx_tvalid = 1'b0; rx_tdata = '0; rx_tkeep = '0; rx_tlast = 1'b0; rx_tuser = '0;
    tx_tready = 1'b1; hdr_tready = 1'b1;
    #1;
    check("rst.rx_tready",  600'(rx_tready),  600'(0));
    check("rst.hdr_tvalid", 600'(hdr_tvalid), 600'(0));
    check("rst.tx_tvalid",  600'(tx_tvalid),  600'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel.rx_tready_pre_edge", 600'(rx_tready), 600'(0));

    // two headers, all readies high
    add(1, 2'b11, 8'h0A, 8'h0B, 8'h01, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  0, 1, 0, 8'h0A, 0, 8'h00);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  0, 1, 1, 8'h0B, 0, 8'h00);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 1, 8'h01);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    // 8 back-to-back header-less beats
    for (int i = 0; i < 8; i++)
      add(1, 2'b00, 8'h00, 8'h00, 8'(8'h10 + i), 1, 1,
          1, 0, 0, 8'h00, (i > 0), 8'(8'h10 + i - 1));
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 1, 8'h17);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    // seg1 header only (seg0 hdr ignored), header stream stalled 5 cycles
    add(1, 2'b10, 8'hEE, 8'h5C, 8'h20, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 5; i++)
      add(1, 2'b00, 8'h00, 8'h00, 8'h21, 1, 0,  0, 1, 1, 8'h5C, 0, 8'h00);
    add(1, 2'b00, 8'h00, 8'h00, 8'h21, 1, 1,  0, 1, 1, 8'h5C, 0, 8'h00);
    add(1, 2'b00, 8'h00, 8'h00, 8'h21, 1, 1,  1, 0, 0, 8'h00, 1, 8'h20);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 1, 8'h21);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    // tx stall with header-less beat held, then retire + capture together
    add(1, 2'b00, 8'h00, 8'h00, 8'h30, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 3; i++)
      add(1, 2'b00, 8'h00, 8'h00, 8'h31, 0, 1,  0, 0, 0, 8'h00, 1, 8'h30);
    add(1, 2'b00, 8'h00, 8'h00, 8'h31, 1, 1,  1, 0, 0, 8'h00, 1, 8'h30);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 1, 8'h31);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    // seg0 header only, tx stalled after the header
    add(1, 2'b01, 8'h77, 8'h88, 8'h40, 0, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 1,  0, 1, 0, 8'h77, 0, 8'h00);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 1,  0, 0, 0, 8'h00, 1, 8'h40);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 1, 8'h40);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    run_vecs();

    // reset while a header is pending: dropped, not replayed
    add(1, 2'b01, 8'h99, 8'h00, 8'h50, 1, 0,  1, 0, 0, 8'h00, 0, 8'h00);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 0,  0, 1, 0, 8'h99, 0, 8'h00);
    run_vecs();
    #1 rst = 1'b1;
    #1;
    check("midrst.hdr_tvalid", 600'(hdr_tvalid), 600'(0));
    check("midrst.tx_tvalid",  600'(tx_tvalid),  600'(0));
    check("midrst.rx_tready",  600'(rx_tready),  600'(0));
    @(negedge clk);
    rst = 1'b0;
    add(1, 2'b00, 8'h00, 8'h00, 8'h51, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 1, 8'h51);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    run_vecs();

`ifdef OFS_FIM_PCIE_SS_HDR_SERIALIZER_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("stats.reset", 600'(hdr_cnt), 600'(0));
    @(negedge clk);
    rst = 1'b0;
    add(1, 2'b11, 8'h60, ~8'h60, 8'h60, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    for (int b = 0; b < 3; b++) begin
      bit [7:0] d, n;
      bit       rv;
      d  = 8'(8'h60 + b);
      n  = 8'(d + 1);
      rv = (b < 2);
      add(rv, 2'b11, n, ~n, n, 1, 1,  0, 1, 0, d,  0, 8'h00);
      add(rv, 2'b11, n, ~n, n, 1, 1,  0, 1, 1, ~d, 0, 8'h00);
      add(rv, 2'b11, n, ~n, n, 1, 1,  1, 0, 0, 8'h00, 1, d);
    end
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    run_vecs();
    check("stats.count6", 600'(hdr_cnt), 600'(6));

    @(negedge clk);
    dut.hdr_cnt_q = 32'hFFFF_FFFE;
    add(1, 2'b11, 8'h70, ~8'h70, 8'h70, 1, 1,  1, 0, 0, 8'h00, 0, 8'h00);
    add(1, 2'b01, 8'h71, ~8'h71, 8'h71, 1, 1,  0, 1, 0, 8'h70, 0, 8'h00);
    add(1, 2'b01, 8'h71, ~8'h71, 8'h71, 1, 1,  0, 1, 1, ~8'h70, 0, 8'h00);
    add(1, 2'b01, 8'h71, ~8'h71, 8'h71, 1, 1,  1, 0, 0, 8'h00, 1, 8'h70);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  0, 1, 0, 8'h71, 0, 8'h00);
    add(0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 1, 8'h71);
    run_vecs();
    check("stats.saturate", 600'(hdr_cnt), 600'(32'hFFFF_FFFF));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
